// File: rtl/if_stage.sv
// Instruction fetch stage: PC, request/grant/response front end to instruction RAM,
// and an allocate-at-issue in-order queue feeding decode through valid/ready.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_instr,
  input  logic        ds_ready
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [31:0]          pc_q;
  logic [31:0]          buf_pc    [BUF_DEPTH];
  logic [31:0]          buf_instr [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_filled;
  logic [BUF_DEPTH-1:0] filled_nxt;

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;

  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] pend_cnt;
  logic [CW-1:0] drop_cnt;

  logic          grant;
  logic          fill;
  logic          drop_rsp;
  logic          xfer;
  logic [SW-1:0] used_cnt;
  logic [SW-1:0] limit_cnt;
  logic [SW-1:0] drop_sum;
  logic          rv_take;
  logic [CW-1:0] drop_flush;
  logic [1:0]    unused_br_lo;

  assign unused_br_lo = br_target[1:0];

  assign fs_valid  = buf_filled[rd_ptr];
  assign fs_pc     = buf_pc[rd_ptr];
  assign fs_instr  = buf_instr[rd_ptr];
  assign inst_addr = pc_q;

  assign xfer     = fs_valid & ds_ready;
  assign drop_rsp = inst_rvalid & (drop_cnt != '0);
  assign fill     = inst_rvalid & (drop_cnt == '0) & (pend_cnt != '0);

  // A transfer or a discarded response frees its credit in the same cycle,
  // which is what sustains one fetch per cycle at the latency limit.
  assign used_cnt  = SW'(alloc_cnt) + SW'(drop_cnt);
  assign limit_cnt = SW'(BUF_DEPTH) + SW'(xfer) + SW'(drop_rsp);
  assign inst_req  = rst_n & ~br_taken & (used_cnt < limit_cnt);
  assign grant     = inst_req & inst_gnt;

  // On redirect every allocated-but-unfilled request becomes a discard,
  // minus a response landing in the redirect cycle itself.
  assign drop_sum   = SW'(drop_cnt) + SW'(pend_cnt);
  assign rv_take    = inst_rvalid & (drop_sum != '0);
  assign drop_flush = CW'(drop_sum - SW'(rv_take));

  always_comb begin
    filled_nxt = buf_filled;
    if (xfer)  filled_nxt[rd_ptr]    = 1'b0;
    if (grant) filled_nxt[alloc_ptr] = 1'b0;
    if (fill)  filled_nxt[fill_ptr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      alloc_cnt  <= '0;
      pend_cnt   <= '0;
      drop_cnt   <= '0;
      buf_filled <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (br_taken) begin
      pc_q       <= {br_target[31:2], 2'b00};
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      alloc_cnt  <= '0;
      pend_cnt   <= '0;
      drop_cnt   <= drop_flush;
      buf_filled <= '0;
    end else begin
      if (grant) begin
        buf_pc[alloc_ptr] <= pc_q;
        alloc_ptr         <= alloc_ptr + PW'(1);
        pc_q              <= pc_q + 32'd4;
      end
      if (fill) begin
        buf_instr[fill_ptr] <= inst_rdata;
        fill_ptr            <= fill_ptr + PW'(1);
      end
      if (drop_rsp) drop_cnt <= drop_cnt - CW'(1);
      if (xfer)     rd_ptr   <= rd_ptr + PW'(1);
      alloc_cnt  <= alloc_cnt + CW'(grant) - CW'(xfer);
      pend_cnt   <= pend_cnt + CW'(grant) - CW'(fill);
      buf_filled <= filled_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, expected fetch pairs queued by the stimulus,
// checked by an independent monitor. A second instance with a wrapping RESET_PC runs in lockstep.
module tb_if_stage;

  localparam logic [31:0] K      = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_gnt = 1'b0;
  logic        inst_rvalid = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        ds_ready = 1'b0;

  logic        inst_req, inst_req_w;
  logic [31:0] inst_addr, inst_addr_w;
  logic        fs_valid, fs_valid_w;
  logic [31:0] fs_pc, fs_pc_w;
  logic [31:0] fs_instr, fs_instr_w;

  if_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_instr(fs_instr), .ds_ready(ds_ready)
  );

  if_stage #(.RESET_PC(WRAP_PC), .BUF_DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req_w), .inst_addr(inst_addr_w), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .fs_valid(fs_valid_w), .fs_pc(fs_pc_w), .fs_instr(fs_instr_w), .ds_ready(ds_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: in-order responses, fixed latency, optional hold.
  typedef struct {logic [31:0] addr; int rdy;} mreq_t;
  mreq_t mq[$];
  int    mem_cyc = 0;
  int    mem_lat = 1;
  bit    mem_hold = 1'b0;
  int    n_grants = 0;

  always @(negedge clk) begin
    mem_cyc++;
    #1;
    if (!rst_n) begin
      mq.delete();
      inst_rvalid = 1'b0;
      inst_rdata  = '0;
      inst_gnt    = 1'b0;
      n_grants    = 0;
    end else begin
      if (!mem_hold && mq.size() > 0 && mq[0].rdy <= mem_cyc) begin
        inst_rvalid = 1'b1;
        inst_rdata  = mq[0].addr ^ K;
        void'(mq.pop_front());
      end else begin
        inst_rvalid = 1'b0;
        inst_rdata  = '0;
      end
      inst_gnt = 1'b1;
      #2;
      if (inst_req && inst_gnt) begin
        mq.push_back('{addr: inst_addr, rdy: mem_cyc + mem_lat});
        n_grants++;
      end
    end
  end

  // Scoreboard
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic [31:0] pc_w;} exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] pc_w);
    exp_q.push_back('{pc: pc, instr: pc ^ K, pc_w: pc_w});
  endtask

  always @(negedge clk) begin
    #3;
    if (rst_n && fs_valid && ds_ready && !br_taken) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got pc %h expected no transfer", fs_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_pc", fs_pc, e.pc);
        chk("xfer_instr", fs_instr, e.instr);
        chk("xfer_valid_w", {31'b0, fs_valid_w}, 32'd1);
        chk("xfer_pc_w", fs_pc_w, e.pc_w);
        chk("xfer_instr_w", fs_instr_w, e.instr);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    ds_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    mem_hold  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int exp_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk({name, "_empty"}, exp_q.size(), 32'd0);
    chk({name, "_cycles"}, n, exp_cyc);
    @(negedge clk);
    ds_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and streaming
    do_reset();
    ds_ready = 1'b1;
    #4;
    chk("t1_req_c1", {31'b0, inst_req}, 32'd1);
    chk("t1_addr_c1", inst_addr, 32'h0);
    chk("t1_addr_w_c1", inst_addr_w, WRAP_PC);
    chk("t1_valid_c1", {31'b0, fs_valid}, 32'd0);
    chk("t1_pc_c1", fs_pc, 32'h0);
    chk("t1_instr_c1", fs_instr, 32'h0);
    push_exp(32'h00, 32'hFFFF_FFF8);
    push_exp(32'h04, 32'hFFFF_FFFC);
    push_exp(32'h08, 32'h0000_0000);
    push_exp(32'h0C, 32'h0000_0004);
    push_exp(32'h10, 32'h0000_0008);
    push_exp(32'h14, 32'h0000_000C);
    step(); #4;
    chk("t1_valid_c2", {31'b0, fs_valid}, 32'd0);
    step(); #4;
    chk("t1_valid_c3", {31'b0, fs_valid}, 32'd1);
    drain("t1", 5);

    // Backpressure
    do_reset();
    ds_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #4;
      if (c == 3) chk("t2_req_c3", {31'b0, inst_req}, 32'd0);
      if (c < 10) step();
    end
    chk("t2_req_c10", {31'b0, inst_req}, 32'd0);
    chk("t2_grants", n_grants, 32'd2);
    chk("t2_pc_hold", fs_pc, 32'h0);
    chk("t2_valid_hold", {31'b0, fs_valid}, 32'd1);
    push_exp(32'h00, 32'hFFFF_FFF8);
    push_exp(32'h04, 32'hFFFF_FFFC);
    push_exp(32'h08, 32'h0000_0000);
    push_exp(32'h0C, 32'h0000_0004);
    step();
    ds_ready = 1'b1;
    #4;
    chk("t2_req_release", {31'b0, inst_req}, 32'd1);
    drain("t2", 3);

    // Redirect with two requests in flight
    do_reset();
    ds_ready = 1'b1;
    mem_hold = 1'b1;
    step();
    step();
    br_taken  = 1'b1;
    br_target = 32'h0000_1003;
    #4;
    chk("t3_req_br", {31'b0, inst_req}, 32'd0);
    step();
    br_taken = 1'b0;
    #4;
    chk("t3_addr_after", inst_addr, 32'h0000_1000);
    chk("t3_addr_w_after", inst_addr_w, 32'h0000_1000);
    chk("t3_req_full_drop", {31'b0, inst_req}, 32'd0);
    chk("t3_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    chk("t3_valid_after", {31'b0, fs_valid}, 32'd0);
    push_exp(32'h1000, 32'h1000);
    push_exp(32'h1004, 32'h1004);
    push_exp(32'h1008, 32'h1008);
    step();
    mem_hold = 1'b0;
    #4;
    chk("t3_req_drop_credit", {31'b0, inst_req}, 32'd1);
    drain("t3", 5);

    // Redirect coincident with a response
    do_reset();
    ds_ready = 1'b0;
    mem_hold = 1'b1;
    step();
    step();
    mem_hold  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h0000_2000;
    #4;
    chk("t4_req_br", {31'b0, inst_req}, 32'd0);
    step();
    br_taken = 1'b0;
    ds_ready = 1'b1;
    #4;
    chk("t4_drop_cnt", 32'(dut.drop_cnt), 32'd1);
    chk("t4_addr", inst_addr, 32'h0000_2000);
    chk("t4_req", {31'b0, inst_req}, 32'd1);
    push_exp(32'h2000, 32'h2000);
    push_exp(32'h2004, 32'h2004);
    step(); #4;
    chk("t4_drop_cnt_zero", 32'(dut.drop_cnt), 32'd0);
    drain("t4", 2);

    // Reset mid-operation with a full queue
    do_reset();
    ds_ready = 1'b0;
    step(); step(); step();
    #4;
    chk("t6_full_valid", {31'b0, fs_valid}, 32'd1);
    chk("t6_full_req", {31'b0, inst_req}, 32'd0);
    step();
    rst_n = 1'b0;
    #4;
    chk("t6_rst_valid", {31'b0, fs_valid}, 32'd0);
    chk("t6_rst_valid_w", {31'b0, fs_valid_w}, 32'd0);
    chk("t6_rst_req", {31'b0, inst_req}, 32'd0);
    step();
    step();
    rst_n    = 1'b1;
    ds_ready = 1'b1;
    #4;
    chk("t6_addr", inst_addr, 32'h0);
    chk("t6_addr_w", inst_addr_w, WRAP_PC);
    chk("t6_req", {31'b0, inst_req}, 32'd1);
    push_exp(32'h00, 32'hFFFF_FFF8);
    push_exp(32'h04, 32'hFFFF_FFFC);
    drain("t6", 3);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
